// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch (I) and load/store (D).
// One transaction is outstanding at a time; the read data is returned to the owning port only.
module mem_port_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int DATA_PRIORITY = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_en,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  localparam logic       OWN_I = 1'b0;
  localparam logic       OWN_D = 1'b1;
  localparam logic [2:0] LAT   = 3'(MEM_LATENCY);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       any_req;
  logic       winner;
  logic       resp_due;

  // Winner selection; on conflict either D always wins or the port that did not go last wins
  always_comb begin
    any_req = i_req | d_req;
    if (i_req && d_req) begin
      if (DATA_PRIORITY != 0) begin
        winner = OWN_D;
      end else begin
        winner = ~last_q;
      end
    end else if (d_req) begin
      winner = OWN_D;
    end else begin
      winner = OWN_I;
    end
  end

  // Next-state logic for the IDLE/WAIT sequencer and latency counter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    last_d   = last_q;
    resp_due = (state_q == ST_WAIT) && (cnt_q == LAT);
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_WAIT;
          cnt_d   = 3'd1;
          owner_d = winner;
          last_d  = winner;
        end else begin
          cnt_d = 3'd0;
        end
      end
      ST_WAIT: begin
        if (resp_due) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Port outputs: grant and memory strobe in IDLE, response to the owner when the latency expires
  always_comb begin
    i_gnt    = 1'b0;
    i_rvalid = 1'b0;
    i_rdata  = {DW{1'b0}};
    d_gnt    = 1'b0;
    d_rvalid = 1'b0;
    d_rdata  = {DW{1'b0}};
    m_en     = 1'b0;
    m_we     = 1'b0;
    m_be     = {(DW/8){1'b0}};
    m_addr   = {AW{1'b0}};
    m_wdata  = {DW{1'b0}};
    if (rst) begin
      m_en = 1'b0;
    end else if ((state_q == ST_IDLE) && any_req) begin
      m_en = 1'b1;
      if (winner == OWN_D) begin
        d_gnt   = 1'b1;
        m_we    = d_we;
        m_be    = d_be;
        m_addr  = d_addr;
        m_wdata = d_wdata;
      end else begin
        i_gnt  = 1'b1;
        m_be   = {(DW/8){1'b1}};
        m_addr = i_addr;
      end
    end else if (resp_due) begin
      if (owner_q == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end else begin
        i_rvalid = 1'b1;
        i_rdata  = m_rdata;
      end
    end else begin
      m_en = 1'b0;
    end
  end

  // State registers; reset drops any outstanding response and hands the next tie to I
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      owner_q <= OWN_D;
      last_q  <= OWN_D;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: three configurations (LAT=1 RR, LAT=3 RR, LAT=1 D-priority)
// checked every cycle against a transaction-level schedule model with its own memory image.
module tb_mem_port_arbiter;

  localparam int N      = 3;
  localparam int CYCLES = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [N];
  logic        i_req    [N];
  logic [31:0] i_addr   [N];
  logic        i_gnt    [N];
  logic        i_rvalid [N];
  logic [31:0] i_rdata  [N];
  logic        d_req    [N];
  logic        d_we     [N];
  logic [3:0]  d_be     [N];
  logic [31:0] d_addr   [N];
  logic [31:0] d_wdata  [N];
  logic        d_gnt    [N];
  logic        d_rvalid [N];
  logic [31:0] d_rdata  [N];
  logic        m_en     [N];
  logic        m_we     [N];
  logic [3:0]  m_be     [N];
  logic [31:0] m_addr   [N];
  logic [31:0] m_wdata  [N];
  logic [31:0] m_rdata  [N];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic logic [31:0] init_word(int i);
    return 32'h1122_3344 + 32'(i) * 32'h0101_0101;
  endfunction

  function automatic int lat_of(int k);
    return (k == 1) ? 3 : 1;
  endfunction

  function automatic bit dpri_of(int k);
    return (k == 2);
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT_G = (g == 1) ? 3 : 1;
    localparam int PRI_G = (g == 2) ? 1 : 0;
    logic [31:0] mem  [16];
    logic [31:0] pipe [4];

    mem_port_arbiter #(
      .AW(32), .DW(32), .MEM_LATENCY(LAT_G), .DATA_PRIORITY(PRI_G)
    ) u_dut (
      .clk(clk), .rst(rst[g]),
      .i_req(i_req[g]), .i_addr(i_addr[g]), .i_gnt(i_gnt[g]),
      .i_rvalid(i_rvalid[g]), .i_rdata(i_rdata[g]),
      .d_req(d_req[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]),
      .d_wdata(d_wdata[g]), .d_gnt(d_gnt[g]), .d_rvalid(d_rvalid[g]), .d_rdata(d_rdata[g]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_be(m_be[g]), .m_addr(m_addr[g]),
      .m_wdata(m_wdata[g]), .m_rdata(m_rdata[g])
    );

    assign m_rdata[g] = pipe[LAT_G-1];

    // Memory array with a read pipeline; idle slots carry random junk so ungated rdata shows up
    always @(posedge clk) begin
      if (rst[g]) begin
        for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      end else if (m_en[g] && m_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (m_be[g][b]) mem[m_addr[g][5:2]][8*b +: 8] <= m_wdata[g][8*b +: 8];
      end
      pipe[0] <= (m_en[g] && !m_we[g]) ? mem[m_addr[g][5:2]] : $urandom();
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Reference model state
  bit          busy     [N];
  int          resp_at  [N];
  bit          own_d    [N];
  bit          last_d   [N];
  bit          was_st   [N];
  logic [31:0] exp_data [N];
  logic [31:0] ref_mem  [N][16];

  // Requester state
  bit          i_pend   [N];
  bit          d_pend   [N];
  logic [31:0] i_h_addr [N];
  logic [31:0] d_h_addr [N];
  logic [31:0] d_h_wd   [N];
  logic [3:0]  d_h_be   [N];
  bit          d_h_we   [N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive_inputs(input int k);
    rst[k] = (cyc < 3) || ($urandom_range(0, 79) == 0);
    if (!i_pend[k]) begin
      if ($urandom_range(0, 3) != 0) begin
        i_pend[k]   = 1'b1;
        i_h_addr[k] = $urandom() & 32'hFFFF_FFFC;
      end
    end else if ($urandom_range(0, 19) == 0) begin
      i_pend[k] = 1'b0;
    end
    if (!d_pend[k]) begin
      if ($urandom_range(0, 3) != 0) begin
        d_pend[k]   = 1'b1;
        d_h_addr[k] = $urandom() & 32'hFFFF_FFFC;
        d_h_wd[k]   = $urandom();
        d_h_be[k]   = 4'($urandom_range(0, 15));
        d_h_we[k]   = ($urandom_range(0, 2) == 0);
      end
    end else if ($urandom_range(0, 19) == 0) begin
      d_pend[k] = 1'b0;
    end
    i_req[k]   = i_pend[k];
    i_addr[k]  = i_pend[k] ? i_h_addr[k] : $urandom();
    d_req[k]   = d_pend[k];
    d_addr[k]  = d_pend[k] ? d_h_addr[k] : $urandom();
    d_wdata[k] = d_pend[k] ? d_h_wd[k] : $urandom();
    d_be[k]    = d_pend[k] ? d_h_be[k] : 4'($urandom_range(0, 15));
    d_we[k]    = d_pend[k] ? d_h_we[k] : ($urandom_range(0, 1) == 0);
  endtask

  task automatic check_cycle(input int k);
    logic [31:0] e_ig, e_iv, e_ir, e_dg, e_dv, e_dr, e_en, e_we, e_be, e_ad, e_wd;
    bit          chk_dr, chk_we, pick_d, is_store;
    int          ix;
    string       p;
    p = $sformatf("u%0d.", k);
    e_ig = 32'd0; e_iv = 32'd0; e_ir = 32'd0; e_dg = 32'd0; e_dv = 32'd0; e_dr = 32'd0;
    e_en = 32'd0; e_we = 32'd0; e_be = 32'd0; e_ad = 32'd0; e_wd = 32'd0;
    chk_dr = 1'b1; chk_we = 1'b0; pick_d = 1'b0; is_store = 1'b0;

    if (rst[k]) begin
      busy[k]   = 1'b0;
      last_d[k] = 1'b1;
      chk_we    = 1'b1;
      for (int i = 0; i < 16; i++) ref_mem[k][i] = init_word(i);
    end else if (busy[k]) begin
      if (cyc == resp_at[k]) begin
        busy[k] = 1'b0;
        if (own_d[k]) begin
          e_dv   = 32'd1;
          e_dr   = exp_data[k];
          chk_dr = !was_st[k];
        end else begin
          e_iv = 32'd1;
          e_ir = exp_data[k];
        end
      end
    end else if (i_req[k] || d_req[k]) begin
      if (i_req[k] && d_req[k]) pick_d = dpri_of(k) ? 1'b1 : !last_d[k];
      else pick_d = d_req[k];
      e_en   = 32'd1;
      chk_we = 1'b1;
      if (pick_d) begin
        ix       = int'(d_addr[k][5:2]);
        e_dg     = 32'd1;
        e_we     = 32'(d_we[k]);
        e_be     = 32'(d_be[k]);
        e_ad     = d_addr[k];
        e_wd     = d_wdata[k];
        is_store = d_we[k];
        exp_data[k] = ref_mem[k][ix];
        if (d_we[k])
          for (int b = 0; b < 4; b++)
            if (d_be[k][b]) ref_mem[k][ix][8*b +: 8] = d_wdata[k][8*b +: 8];
        d_pend[k] = 1'b0;
      end else begin
        ix   = int'(i_addr[k][5:2]);
        e_ig = 32'd1;
        e_be = 32'hF;
        e_ad = i_addr[k];
        exp_data[k] = ref_mem[k][ix];
        i_pend[k] = 1'b0;
      end
      own_d[k]   = pick_d;
      last_d[k]  = pick_d;
      was_st[k]  = is_store;
      busy[k]    = 1'b1;
      resp_at[k] = cyc + lat_of(k);
    end

    check_eq({p, "i_gnt"},    32'(i_gnt[k]),    e_ig);
    check_eq({p, "d_gnt"},    32'(d_gnt[k]),    e_dg);
    check_eq({p, "i_rvalid"}, 32'(i_rvalid[k]), e_iv);
    check_eq({p, "d_rvalid"}, 32'(d_rvalid[k]), e_dv);
    check_eq({p, "i_rdata"},  i_rdata[k],       e_ir);
    if (chk_dr) check_eq({p, "d_rdata"}, d_rdata[k], e_dr);
    check_eq({p, "m_en"},     32'(m_en[k]),     e_en);
    if (chk_we) check_eq({p, "m_we"}, 32'(m_we[k]), e_we);
    if (e_en != 32'd0) begin
      check_eq({p, "m_be"},   32'(m_be[k]),     e_be);
      check_eq({p, "m_addr"}, m_addr[k],        e_ad);
      if (is_store) check_eq({p, "m_wdata"}, m_wdata[k], e_wd);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1; i_req[k] = 1'b0; d_req[k] = 1'b0; i_addr[k] = 32'd0;
      d_addr[k] = 32'd0; d_wdata[k] = 32'd0; d_be[k] = 4'd0; d_we[k] = 1'b0;
      i_pend[k] = 1'b0; d_pend[k] = 1'b0; busy[k] = 1'b0; last_d[k] = 1'b1;
    end
    for (cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) drive_inputs(k);
      @(negedge clk);
      for (int k = 0; k < N; k++) check_cycle(k);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
